// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the pipeline stages.
//   INST_W    instruction word width
//   ADDR_W    default PC / byte-address width
//   NOP_INST  bubble word (opcode 000000 = no-op)
//   OP_*      opcode field values used by decode and the branch unit
//   if_id_t   contents of the IF/ID pipeline register
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register for the fetch stage.
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   load_en      update the PC on this edge (held otherwise)
//   load_sel     1 = load word-aligned branch_addr, 0 = load pc + 4
//   branch_addr  redirect target; bits [1:0] are forced to zero
//   pc           current PC
//   pc_plus4     pc + 4, modulo 2^ADDR_W
module pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    assign pc_plus4 = pc + ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= load_sel ? (branch_addr & WORD_MASK) : pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Holds the PC, addresses the
// zero-latency instruction ROM and captures its word into IF/ID.
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   freeze        hold PC and IF/ID
//   branch_taken  redirect to branch_addr and flush IF/ID (beats freeze)
//   branch_addr   redirect target byte address (bits [1:0] ignored)
//   rom_address   byte address to the ROM, equal to the current PC
//   rom_inst      combinational ROM word at rom_address
//   if_pc         PC+4 of the instruction held in IF/ID
//   if_inst       instruction held in IF/ID
//   if_valid      1 = real instruction, 0 = bubble
// Optional build macro FETCH_PERF_CNT_EN adds saturating 32-bit counters
//   perf_fetched, perf_stalled, perf_flushed.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [31:0]       rom_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst,
    output logic              if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalled,
    output logic [31:0]       perf_flushed
`endif
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              do_fetch;

    // A branch must still load the PC while frozen.
    assign do_fetch = !branch_taken && !freeze;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .load_en     (branch_taken || !freeze),
        .load_sel    (branch_taken),
        .branch_addr (branch_addr),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    assign rom_address = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc    <= '0;
            if_inst  <= NOP_INST;
            if_valid <= 1'b0;
        end else if (branch_taken) begin
            // The word on rom_inst is wrong-path; replace it with a bubble.
            if_pc    <= '0;
            if_inst  <= NOP_INST;
            if_valid <= 1'b0;
        end else if (do_fetch) begin
            if_pc    <= pc_plus4;
            if_inst  <= rom_inst;
            if_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalled <= '0;
            perf_flushed <= '0;
        end else if (branch_taken) begin
            if (perf_flushed != 32'hFFFF_FFFF) perf_flushed <= perf_flushed + 32'd1;
        end else if (freeze) begin
            if (perf_stalled != 32'hFFFF_FFFF) perf_stalled <= perf_stalled + 32'd1;
        end else begin
            if (perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] rom_address;
    logic [31:0] rom_inst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalled;
    logic [31:0] perf_flushed;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .rom_address  (rom_address),
        .rom_inst     (rom_inst),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stalled (perf_stalled),
        .perf_flushed (perf_flushed)
`endif
    );

    // ROM contents: each word encodes its own address so captures are traceable.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    assign rom_inst = rom_word(rom_address);

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference model: architectural view of the stage as the rules describe it.
    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_valid;
    longint      m_fetched, m_stalled, m_flushed;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
            m_fetched = 0; m_stalled = 0; m_flushed = 0;
        end else if (branch_taken) begin
            m_pc    = {branch_addr[31:2], 2'b00};
            m_ifpc  = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
            m_flushed = (m_flushed < 64'hFFFF_FFFF) ? m_flushed + 1 : m_flushed;
        end else if (freeze) begin
            m_stalled = (m_stalled < 64'hFFFF_FFFF) ? m_stalled + 1 : m_stalled;
        end else begin
            m_inst  = rom_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_fetched = (m_fetched < 64'hFFFF_FFFF) ? m_fetched + 1 : m_fetched;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_rom_address", rom_address, m_pc);
            check("m_if_pc", if_pc, m_ifpc);
            check("m_if_inst", if_inst, m_inst);
            check("m_if_valid", {31'b0, if_valid}, {31'b0, m_valid});
`ifdef FETCH_PERF_CNT_EN
            check("m_perf_fetched", perf_fetched, m_fetched[31:0]);
            check("m_perf_stalled", perf_stalled, m_stalled[31:0]);
            check("m_perf_flushed", perf_flushed, m_flushed[31:0]);
`endif
        end
    end

    // Apply inputs for one edge, then return 1 time unit after the next falling edge.
    task automatic step(input logic fr, input logic br, input logic [31:0] ba);
        freeze = fr; branch_taken = br; branch_addr = ba;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic [31:0] ra, input logic [31:0] ipc,
                       input logic [31:0] iinst, input logic ival);
        check({tag, "_rom_address"}, rom_address, ra);
        check({tag, "_if_pc"}, if_pc, ipc);
        check({tag, "_if_inst"}, if_inst, iinst);
        check({tag, "_if_valid"}, {31'b0, if_valid}, {31'b0, ival});
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        @(negedge clk);
        #1;
        lit("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Sequential fetch from reset.
        step(0, 0, 0); lit("seq1", 32'h04, 32'h04, 32'h1000_0000, 1'b1);
        step(0, 0, 0); lit("seq2", 32'h08, 32'h08, 32'h1000_0004, 1'b1);
        step(0, 0, 0); lit("seq3", 32'h0C, 32'h0C, 32'h1000_0008, 1'b1);
        step(0, 0, 0); lit("seq4", 32'h10, 32'h10, 32'h1000_000C, 1'b1);

        // Freeze two cycles at pc=0x10, then release.
        step(1, 0, 0); lit("frz1", 32'h10, 32'h10, 32'h1000_000C, 1'b1);
        step(1, 0, 0); lit("frz2", 32'h10, 32'h10, 32'h1000_000C, 1'b1);
        step(0, 0, 0); lit("frz_rel", 32'h14, 32'h14, 32'h1000_0010, 1'b1);

        // Branch at pc=0x14 to 0x38.
        step(0, 1, 32'h38); lit("br", 32'h38, 32'h0, 32'h0, 1'b0);
        step(0, 0, 0);      lit("br_tgt", 32'h3C, 32'h3C, 32'h1000_0038, 1'b1);
        step(0, 0, 0);      lit("br_tgt2", 32'h40, 32'h40, 32'h1000_003C, 1'b1);

        // Branch beats freeze; low address bits masked.
        step(1, 1, 32'h3B); lit("br_frz", 32'h38, 32'h0, 32'h0, 1'b0);
        step(0, 0, 0);
        step(0, 0, 0);      lit("pre_rst", 32'h40, 32'h40, 32'h1000_003C, 1'b1);

        // Asynchronous reset between edges with a pending branch and freeze.
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h80;
        #2 rst = 1'b1;
        #1 lit("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        #1 rst = 1'b0;
        step(0, 0, 0); lit("post_rst", 32'h04, 32'h04, 32'h1000_0000, 1'b1);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFF); lit("wrap_br", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        step(0, 0, 0);             lit("wrap", 32'h0, 32'h0, 32'h0FFF_FFFC, 1'b1);

        // Self-jump: redirecting to if_pc-4 repeatedly re-fetches one address.
        step(0, 1, 32'h20);
        step(0, 0, 0);
        step(0, 1, if_pc - 32'd4); lit("self_jmp", 32'h20, 32'h0, 32'h0, 1'b0);

        // Counter scenario: 6 fetch, 3 freeze, 1 branch after a fresh reset.
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0); step(1, 0, 0);
        step(0, 1, 32'h100);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0);
        lit("perf_end", 32'h10C, 32'h10C, 32'h1000_0108, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd6);
        check("perf_stalled", perf_stalled, 32'd3);
        check("perf_flushed", perf_flushed, 32'd1);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage CPU pipeline; sits directly upstream of the instruction ROM and of the ID stage.
- Holds the program counter and drives the ROM's byte address. Captures the combinational ROM word into the IF/ID pipeline register.
- Applies stall (freeze) requests from hazard detection and redirect requests from the branch unit in EXE.

Parameters:
- ADDR_W, 32, PC and address width in bits.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0000, bubble word inserted on flush/reset (opcode 000000 = no-op).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hazard stall: hold PC and IF/ID contents.
- branch_taken  in  1  redirect request from EXE, valid for one cycle.
- branch_addr  in  ADDR_W  redirect target byte address; bits [1:0] are ignored and treated as 0.
- rom_address  out  ADDR_W  byte address to instruction ROM; equals the current PC.
- rom_inst  in  32  instruction word returned combinationally by the ROM.
- if_pc  out  ADDR_W  registered PC+4 of the instruction held in IF/ID.
- if_inst  out  32  registered instruction to ID.
- if_valid  out  1  1 = if_inst is a real fetched instruction; 0 = bubble.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC, so rom_address = RESET_PC.
  - if_pc = 0, if_inst = NOP_INST, if_valid = 0.
  - All three optional counters = 0.
- The first rising edge after rst deasserts captures the word at RESET_PC. Word 0 is a dummy by program convention.
- rom_address is driven combinationally from the pc register. It has zero ROM latency; the word is captured on the next edge.
- Per rising edge, priority highest first:
  1. branch_taken=1, regardless of freeze:
     - pc <= {branch_addr[ADDR_W-1:2], 2'b00}.
     - IF/ID <= bubble: if_inst = NOP_INST, if_valid = 0, if_pc = 0.
     - The wrong-path word currently on rom_inst is discarded.
  2. freeze=1: pc, if_pc, if_inst and if_valid all hold.
  3. Otherwise:
     - pc <= pc + 4.
     - if_inst <= rom_inst, if_pc <= pc + 4, if_valid <= 1.
- Arithmetic: pc + 4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0. No overflow flag.
- Branch targets are computed downstream as (PC+4) + (sign-extended offset << 2), and if_pc supplies that PC+4. A self-jump (offset -1) therefore re-fetches the same address every time it resolves.
- Reset asserted mid-operation overrides everything asynchronously, including a pending branch or freeze.
- No internal state machine beyond the PC/valid registers. Stall and flush are level-sampled each edge with no memory of past requests.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds three 32-bit outputs: perf_fetched (counts edges taking rule 3), perf_stalled (rule 2), perf_flushed (rule 1).
  - Counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - INST_W=32, ADDR_W default, NOP_INST, opcode constants (OP_ADDI=6'b100000, OP_BEZ=6'b101000, OP_BNE=6'b101001, OP_JMP=6'b101010).
  - Typedef if_id_t {pc, inst, valid}.
- One natural sub-module: pc_reg. It is the PC register with async reset, load-enable (not freeze or branch) and load-select (branch_addr vs pc+4).
- The IF/ID register stays inline in fetch_stage.

Test Plan:
- Reset release, no freeze or branch, ROM preloaded: rom_address goes 0, 4, 8, 12 on successive cycles; if_pc goes 4, 8, 12; if_inst equals the words at 0, 4, 8; if_valid goes 1 from the first edge.
- freeze held 2 cycles with pc=0x10:
  - rom_address stays 0x10 and IF/ID holds the prior word with if_pc=0x10.
  - After release, the next edge captures word 0x10 with if_pc=0x14.
- branch_taken with branch_addr=0x38 at pc=0x14: next cycle rom_address=0x38, if_valid=0, if_inst=0; the following edge captures word 0x38 with if_pc=0x3C.
- branch_taken and freeze both asserted, branch_addr=0x3B: pc becomes 0x38 (low bits masked) and IF/ID is flushed, showing branch priority over freeze.
- rst pulsed asynchronously mid-cycle between edges at pc=0x40: outputs return to reset values immediately, without waiting for a clock edge; the first post-reset edge captures word 0.
- With FETCH_PERF_CNT_EN defined: 10 cycles comprising 6 fetch, 3 freeze and 1 branch give perf_fetched=6, perf_stalled=3, perf_flushed=1.
